// File: rtl/silent_lpf_v3.sv
// -----------------------------------------------------------------------------
// silent_lpf_v3
// Slew-rate limiter for per-transducer duty and phase. Each accepted UPDATE
// launches one sequential pass over all channels, moving every channel's
// current value toward its captured target by at most the captured step.
// Duty saturates at the target; phase takes the shortest circular path.
//
// Ports
//   CLK, RST_N         rising-edge clock, synchronous active-low reset
//   ENABLE             1: slew-limited outputs, 0: outputs bypass to inputs
//   UPDATE             single-cycle pass request (merged into one pending)
//   STEP_DUTY/PHASE    per-pass maximum change, sampled at pass start
//   DUTY/PHASE         per-channel targets
//   DUTYS/PHASES       per-channel limited outputs
//   OUT_VALID          one-cycle pulse in the cycle after the last write
//   BUSY               pass in progress
//   SETTLED            all channels reached target at end of last pass
// -----------------------------------------------------------------------------
module silent_lpf_v3 #(
    parameter int TRANS_NUM = 249,
    parameter int WIDTH     = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             ENABLE,
    input  logic             UPDATE,
    input  logic [WIDTH-1:0] STEP_DUTY,
    input  logic [WIDTH-1:0] STEP_PHASE,
    input  logic [WIDTH-1:0] DUTY   [0:TRANS_NUM-1],
    input  logic [WIDTH-1:0] PHASE  [0:TRANS_NUM-1],
    output logic [WIDTH-1:0] DUTYS  [0:TRANS_NUM-1],
    output logic [WIDTH-1:0] PHASES [0:TRANS_NUM-1],
    output logic             OUT_VALID,
    output logic             BUSY,
    output logic             SETTLED
);

    localparam int IW = $clog2(TRANS_NUM);
    // Pass counter runs 0..TRANS_NUM+2: reads, pipeline drain, and the
    // OUT_VALID cycle that hands over to a pending pass.
    localparam int CW = $clog2(TRANS_NUM + 3);

    typedef enum logic {IDLE, PROCESS} state_t;

    // Duty never wraps: move toward target, clamped by step and target.
    function automatic logic [WIDTH-1:0] slew_duty(
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] tgt,
        input logic [WIDTH-1:0] step
    );
        logic [WIDTH-1:0] diff;
        if (tgt >= cur) begin
            diff = tgt - cur;
            return cur + ((diff < step) ? diff : step);
        end
        diff = cur - tgt;
        return cur - ((diff < step) ? diff : step);
    endfunction

    // Phase is circular: the MSB of the modular difference picks direction,
    // so a half-turn difference (MSB set) moves negative.
    function automatic logic [WIDTH-1:0] slew_phase(
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] tgt,
        input logic [WIDTH-1:0] step
    );
        logic [WIDTH-1:0] diff;
        logic [WIDTH-1:0] mag;
        diff = tgt - cur;
        if (diff[WIDTH-1]) begin
            mag = cur - tgt;
            return cur - ((mag < step) ? mag : step);
        end
        return cur + ((diff < step) ? diff : step);
    endfunction

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             pending_q, pending_d;
    logic [WIDTH-1:0] step_duty_q, step_duty_d;
    logic [WIDTH-1:0] step_phase_q, step_phase_d;
    logic [WIDTH-1:0] tgt_duty_q  [0:TRANS_NUM-1];
    logic [WIDTH-1:0] tgt_duty_d  [0:TRANS_NUM-1];
    logic [WIDTH-1:0] tgt_phase_q [0:TRANS_NUM-1];
    logic [WIDTH-1:0] tgt_phase_d [0:TRANS_NUM-1];
    logic [WIDTH-1:0] cur_duty_q  [0:TRANS_NUM-1];
    logic [WIDTH-1:0] cur_duty_d  [0:TRANS_NUM-1];
    logic [WIDTH-1:0] cur_phase_q [0:TRANS_NUM-1];
    logic [WIDTH-1:0] cur_phase_d [0:TRANS_NUM-1];

    // vld_pipe bit 0: read stage holds a channel, bit 1: compute stage does.
    logic [1:0]       vld_pipe_q, vld_pipe_d;
    logic [IW-1:0]    s1_idx_q, s1_idx_d;
    logic [WIDTH-1:0] s1_duty_cur_q, s1_duty_cur_d;
    logic [WIDTH-1:0] s1_duty_tgt_q, s1_duty_tgt_d;
    logic [WIDTH-1:0] s1_phase_cur_q, s1_phase_cur_d;
    logic [WIDTH-1:0] s1_phase_tgt_q, s1_phase_tgt_d;
    logic [IW-1:0]    s2_idx_q, s2_idx_d;
    logic [WIDTH-1:0] s2_duty_q, s2_duty_d;
    logic [WIDTH-1:0] s2_phase_q, s2_phase_d;
    logic             s2_ok_q, s2_ok_d;
    logic             settle_acc_q, settle_acc_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             settled_q, settled_d;

    logic             rd_vld;
    logic             last_wb;
    logic             accept;
    logic             req_any;
    logic [IW-1:0]    rd_idx;

    assign rd_vld  = (state_q == PROCESS) && (cnt_q < CW'(TRANS_NUM));
    assign last_wb = (state_q == PROCESS) && (cnt_q == CW'(TRANS_NUM + 1));
    // Handover slot (cnt = TRANS_NUM+2) is only reached with a request pending.
    assign accept  = ((state_q == IDLE) && UPDATE) ||
                     ((state_q == PROCESS) && (cnt_q == CW'(TRANS_NUM + 2)));
    assign req_any = pending_q | UPDATE;
    assign rd_idx  = rd_vld ? cnt_q[IW-1:0] : '0;

    // Control and sampling
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pending_d    = pending_q;
        step_duty_d  = step_duty_q;
        step_phase_d = step_phase_q;
        tgt_duty_d   = tgt_duty_q;
        tgt_phase_d  = tgt_phase_q;
        if (accept) begin
            state_d      = PROCESS;
            cnt_d        = '0;
            pending_d    = 1'b0;
            step_duty_d  = STEP_DUTY;
            step_phase_d = STEP_PHASE;
            tgt_duty_d   = DUTY;
            tgt_phase_d  = PHASE;
        end else if (state_q == PROCESS) begin
            cnt_d     = cnt_q + CW'(1);
            pending_d = req_any;
            if (last_wb && !req_any) begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        end
        busy_d      = (state_d == PROCESS);
        out_valid_d = last_wb;
    end

    // Read / compute / write-back pipeline
    always_comb begin
        vld_pipe_d     = {vld_pipe_q[0], rd_vld};
        s1_idx_d       = rd_idx;
        s1_duty_cur_d  = cur_duty_q[rd_idx];
        s1_duty_tgt_d  = tgt_duty_q[rd_idx];
        s1_phase_cur_d = cur_phase_q[rd_idx];
        s1_phase_tgt_d = tgt_phase_q[rd_idx];

        s2_idx_d = s1_idx_q;
        if (ENABLE) begin
            s2_duty_d  = slew_duty(s1_duty_cur_q, s1_duty_tgt_q, step_duty_q);
            s2_phase_d = slew_phase(s1_phase_cur_q, s1_phase_tgt_q, step_phase_q);
        end else begin
            s2_duty_d  = s1_duty_tgt_q;
            s2_phase_d = s1_phase_tgt_q;
        end
        s2_ok_d = (s2_duty_d == s1_duty_tgt_q) && (s2_phase_d == s1_phase_tgt_q);

        cur_duty_d   = cur_duty_q;
        cur_phase_d  = cur_phase_q;
        settle_acc_d = settle_acc_q;
        settled_d    = settled_q;
        if (accept)
            settle_acc_d = 1'b1;
        if (vld_pipe_q[1]) begin
            cur_duty_d[s2_idx_q]  = s2_duty_q;
            cur_phase_d[s2_idx_q] = s2_phase_q;
            settle_acc_d          = settle_acc_q & s2_ok_q;
        end
        if (last_wb)
            settled_d = settle_acc_q & s2_ok_q;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            pending_q      <= 1'b0;
            step_duty_q    <= '0;
            step_phase_q   <= '0;
            for (int i = 0; i < TRANS_NUM; i++) begin
                tgt_duty_q[i]  <= '0;
                tgt_phase_q[i] <= '0;
                cur_duty_q[i]  <= '0;
                cur_phase_q[i] <= '0;
            end
            vld_pipe_q     <= '0;
            s1_idx_q       <= '0;
            s1_duty_cur_q  <= '0;
            s1_duty_tgt_q  <= '0;
            s1_phase_cur_q <= '0;
            s1_phase_tgt_q <= '0;
            s2_idx_q       <= '0;
            s2_duty_q      <= '0;
            s2_phase_q     <= '0;
            s2_ok_q        <= 1'b0;
            settle_acc_q   <= 1'b1;
            out_valid_q    <= 1'b0;
            busy_q         <= 1'b0;
            settled_q      <= 1'b1;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            pending_q      <= pending_d;
            step_duty_q    <= step_duty_d;
            step_phase_q   <= step_phase_d;
            tgt_duty_q     <= tgt_duty_d;
            tgt_phase_q    <= tgt_phase_d;
            cur_duty_q     <= cur_duty_d;
            cur_phase_q    <= cur_phase_d;
            vld_pipe_q     <= vld_pipe_d;
            s1_idx_q       <= s1_idx_d;
            s1_duty_cur_q  <= s1_duty_cur_d;
            s1_duty_tgt_q  <= s1_duty_tgt_d;
            s1_phase_cur_q <= s1_phase_cur_d;
            s1_phase_tgt_q <= s1_phase_tgt_d;
            s2_idx_q       <= s2_idx_d;
            s2_duty_q      <= s2_duty_d;
            s2_phase_q     <= s2_phase_d;
            s2_ok_q        <= s2_ok_d;
            settle_acc_q   <= settle_acc_d;
            out_valid_q    <= out_valid_d;
            busy_q         <= busy_d;
            settled_q      <= settled_d;
        end
    end

    // Bypass mux is purely combinational; since disabled passes copy targets
    // into the current registers, re-enabling does not step the outputs.
    always_comb begin
        for (int i = 0; i < TRANS_NUM; i++) begin
            DUTYS[i]  = ENABLE ? cur_duty_q[i]  : DUTY[i];
            PHASES[i] = ENABLE ? cur_phase_q[i] : PHASE[i];
        end
    end

    assign OUT_VALID = out_valid_q;
    assign BUSY      = busy_q;
    assign SETTLED   = settled_q;

endmodule

// File: tb/tb_silent_lpf_v3.sv
module tb_silent_lpf_v3;

    localparam int N = 4;
    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         enable;
    logic         update;
    logic [W-1:0] step_duty;
    logic [W-1:0] step_phase;
    logic [W-1:0] duty   [0:N-1];
    logic [W-1:0] phase  [0:N-1];
    logic [W-1:0] dutys  [0:N-1];
    logic [W-1:0] phases [0:N-1];
    logic         out_valid;
    logic         busy;
    logic         settled;

    int checks = 0;
    int errors = 0;

    silent_lpf_v3 #(.TRANS_NUM(N), .WIDTH(W)) dut (
        .CLK(clk), .RST_N(rst_n), .ENABLE(enable), .UPDATE(update),
        .STEP_DUTY(step_duty), .STEP_PHASE(step_phase),
        .DUTY(duty), .PHASE(phase), .DUTYS(dutys), .PHASES(phases),
        .OUT_VALID(out_valid), .BUSY(busy), .SETTLED(settled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_duty_all(input logic [W-1:0] v);
        for (int i = 0; i < N; i++) duty[i] = v;
    endtask

    task automatic set_phase_all(input logic [W-1:0] v);
        for (int i = 0; i < N; i++) phase[i] = v;
    endtask

    // Launch a pass and return the cycle (relative to accept) of OUT_VALID,
    // or -1 if it never arrives within the budget. Ends at that cycle's negedge.
    task automatic run_pass(output int ov_cyc, output logic busy1);
        ov_cyc = -1;
        busy1  = 1'b0;
        @(negedge clk);
        update = 1'b1;
        @(posedge clk);
        #1 update = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) busy1 = busy;
            if (out_valid) begin
                ov_cyc = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable = 1'b1;
        update = 1'b0;
        step_duty = '0;
        step_phase = '0;
        set_duty_all(8'd0);
        set_phase_all(8'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (dutys[i] !== 8'd0 || phases[i] !== 8'd0) begin
                errors++;
                $display("FAIL reset_out ch%0d: duty=%0d phase=%0d expected 0/0", i, dutys[i], phases[i]);
            end
        end
        checks++;
        if ({out_valid, busy, settled} !== 3'b001) begin
            errors++;
            $display("FAIL reset_status: ov/busy/settled=%b expected 001", {out_valid, busy, settled});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_duty_ramp();
        int   exp_d [4] = '{3, 6, 9, 10};
        logic exp_s [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        int   ov;
        logic b1;
        set_duty_all(8'd10);
        step_duty = 8'd3;
        for (int p = 0; p < 4; p++) begin
            run_pass(ov, b1);
            checks++;
            if (ov !== 7 || b1 !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL ramp_timing pass%0d: ov_cycle=%0d busy1=%b busy_at_ov=%b expected 7/1/0", p, ov, b1, busy);
            end
            for (int i = 0; i < N; i++) begin
                checks++;
                if (dutys[i] !== W'(exp_d[p])) begin
                    errors++;
                    $display("FAIL ramp_duty pass%0d ch%0d: got %0d expected %0d", p, i, dutys[i], exp_d[p]);
                end
            end
            checks++;
            if (settled !== exp_s[p]) begin
                errors++;
                $display("FAIL ramp_settled pass%0d: got %b expected %b", p, settled, exp_s[p]);
            end
        end
    endtask

    task automatic test_duty_down();
        int   exp_d [4] = '{7, 4, 1, 0};
        int   ov;
        logic b1;
        set_duty_all(8'd0);
        for (int p = 0; p < 4; p++) begin
            run_pass(ov, b1);
            for (int i = 0; i < N; i++) begin
                checks++;
                if (ov !== 7 || dutys[i] !== W'(exp_d[p])) begin
                    errors++;
                    $display("FAIL down_duty pass%0d ch%0d: got %0d (ov %0d) expected %0d (ov 7)", p, i, dutys[i], ov, exp_d[p]);
                end
            end
        end
    endtask

    task automatic test_phase_wrap();
        int   exp_a [3] = '{254, 2, 5};
        int   exp_b [2] = '{156, 128};
        int   ov;
        logic b1;
        // Preload current phase 250 through a bypass pass.
        enable = 1'b0;
        set_phase_all(8'd250);
        run_pass(ov, b1);
        enable = 1'b1;
        set_phase_all(8'd5);
        step_phase = 8'd4;
        #1;
        checks++;
        if (phases[0] !== 8'd250) begin
            errors++;
            $display("FAIL wrap_preload: got %0d expected 250", phases[0]);
        end
        for (int p = 0; p < 3; p++) begin
            run_pass(ov, b1);
            for (int i = 0; i < N; i++) begin
                checks++;
                if (phases[i] !== W'(exp_a[p])) begin
                    errors++;
                    $display("FAIL wrap_up pass%0d ch%0d: got %0d expected %0d", p, i, phases[i], exp_a[p]);
                end
            end
        end
        // Half-turn difference must move negative.
        enable = 1'b0;
        set_phase_all(8'd0);
        run_pass(ov, b1);
        enable = 1'b1;
        set_phase_all(8'd128);
        step_phase = 8'd100;
        for (int p = 0; p < 2; p++) begin
            run_pass(ov, b1);
            for (int i = 0; i < N; i++) begin
                checks++;
                if (phases[i] !== W'(exp_b[p])) begin
                    errors++;
                    $display("FAIL wrap_half pass%0d ch%0d: got %0d expected %0d", p, i, phases[i], exp_b[p]);
                end
            end
        end
        checks++;
        if (settled !== 1'b1) begin
            errors++;
            $display("FAIL wrap_settled: got %b expected 1", settled);
        end
    endtask

    task automatic test_pending();
        int ov_at [2] = '{-1, -1};
        int n_ov = 0;
        int busy_drop = 0;
        logic [W-1:0] first  [4] = '{8'd20, 8'd40, 8'd60, 8'd80};
        logic [W-1:0] second [4] = '{8'd5, 8'd6, 8'd7, 8'd8};
        for (int i = 0; i < N; i++) duty[i] = first[i];
        step_duty = 8'd255;
        step_phase = 8'd0;
        @(negedge clk);
        update = 1'b1;
        @(posedge clk);
        #1 update = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (c == 2) begin
                update = 1'b1;
                for (int i = 0; i < N; i++) duty[i] = second[i];
            end
            if (c == 3) update = 1'b0;
            if (c == 4) begin
                checks++;
                if (dutys[0] !== 8'd20 || dutys[1] !== 8'd0) begin
                    errors++;
                    $display("FAIL pend_ch_timing: ch0=%0d ch1=%0d expected 20/0", dutys[0], dutys[1]);
                end
            end
            if (c <= 13 && !busy) busy_drop++;
            if (c == 14) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL pend_busy_end: got %b expected 0", busy);
                end
            end
            if (out_valid) begin
                if (n_ov < 2) ov_at[n_ov] = c;
                n_ov++;
                for (int i = 0; i < N; i++) begin
                    checks++;
                    if (c == 7 && dutys[i] !== first[i]) begin
                        errors++;
                        $display("FAIL pend_pass1 ch%0d: got %0d expected %0d", i, dutys[i], first[i]);
                    end else if (c == 14 && dutys[i] !== second[i]) begin
                        errors++;
                        $display("FAIL pend_pass2 ch%0d: got %0d expected %0d", i, dutys[i], second[i]);
                    end
                end
            end
        end
        checks++;
        if (n_ov !== 2 || ov_at[0] !== 7 || ov_at[1] !== 14) begin
            errors++;
            $display("FAIL pend_ov: count=%0d at %0d,%0d expected 2 at 7,14", n_ov, ov_at[0], ov_at[1]);
        end
        checks++;
        if (busy_drop !== 0) begin
            errors++;
            $display("FAIL pend_busy: dropped %0d cycles expected 0", busy_drop);
        end
    endtask

    task automatic test_enable();
        int   ov;
        logic b1;
        enable = 1'b0;
        set_duty_all(8'd200);
        #1;
        for (int i = 0; i < N; i++) begin
            checks++;
            if (dutys[i] !== 8'd200) begin
                errors++;
                $display("FAIL bypass ch%0d: got %0d expected 200", i, dutys[i]);
            end
        end
        step_duty = 8'd3;
        run_pass(ov, b1);
        enable = 1'b1;
        #1;
        for (int i = 0; i < N; i++) begin
            checks++;
            if (dutys[i] !== 8'd200) begin
                errors++;
                $display("FAIL reenable ch%0d: got %0d expected 200", i, dutys[i]);
            end
        end
        checks++;
        if (ov !== 7 || settled !== 1'b1) begin
            errors++;
            $display("FAIL bypass_pass: ov=%0d settled=%b expected 7/1", ov, settled);
        end
    endtask

    task automatic test_abort();
        int   n_ov = 0;
        int   n_busy = 0;
        int   ov;
        logic b1;
        set_duty_all(8'd50);
        step_duty = 8'd3;
        @(negedge clk);
        update = 1'b1;
        @(posedge clk);
        #1 update = 1'b0;
        @(negedge clk);            // cycle 1
        @(negedge clk);            // cycle 2: queue a pending request
        update = 1'b1;
        @(negedge clk);            // cycle 3
        update = 1'b0;
        checks++;
        if (dutys[0] !== 8'd200) begin
            errors++;
            $display("FAIL abort_pre: got %0d expected 200", dutys[0]);
        end
        rst_n = 1'b0;
        @(negedge clk);            // cycle 4
        for (int i = 0; i < N; i++) begin
            checks++;
            if (dutys[i] !== 8'd0) begin
                errors++;
                $display("FAIL abort_out ch%0d: got %0d expected 0", i, dutys[i]);
            end
        end
        checks++;
        if ({out_valid, busy, settled} !== 3'b001) begin
            errors++;
            $display("FAIL abort_status: ov/busy/settled=%b expected 001", {out_valid, busy, settled});
        end
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (out_valid) n_ov++;
            if (busy) n_busy++;
        end
        checks++;
        if (n_ov !== 0 || n_busy !== 0) begin
            errors++;
            $display("FAIL abort_drop: ov=%0d busy=%0d expected 0/0", n_ov, n_busy);
        end
        run_pass(ov, b1);
        checks++;
        if (ov !== 7 || dutys[3] !== 8'd3) begin
            errors++;
            $display("FAIL abort_recover: ov=%0d duty=%0d expected 7/3", ov, dutys[3]);
        end
    endtask

    initial begin
        test_reset();
        test_duty_ramp();
        test_duty_down();
        test_phase_wrap();
        test_pending();
        test_enable();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
